// File: rtl/node_iface.sv
// node_iface -- local-node endpoint on port 4 (inject/eject) of the deflection router.
//
// TX side: core requests are stamped with this node's address and a rolling
// sequence number. Each one is then queued and offered to the router on port4_ci.
// The head entry is retired on port4_ack. A starvation counter tracks how long the
// head has been refused.
//
// RX side: the router ejects flits on port4_co and gives no backpressure. Each
// ejected flit is captured into an RX FIFO, and the core drains that FIFO with
// rx_valid/rx_ready. Requests addressed to this node skip the router and go
// straight into the RX FIFO.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   tx_valid/tx_ready          core request handshake
//   tx_dest, tx_payload        request destination and payload
//   port4_ci                   flit offered to the router (all-zero when idle)
//   port4_ack                  router consumed port4_ci this cycle
//   port4_co                   ejected flit (MSB = valid)
//   rx_valid/rx_ready/rx_data  RX FIFO head and drain handshake
//   starve                     head flit refused for >= STARVE_TH cycles
//   rx_overflow                sticky: an ejected flit was dropped
//
// Flit layout: {valid, payload, seq, src, dest}, with dest in the LSBs.
module node_iface #(
    parameter int                ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] ADDR      = 4'b0101,
    parameter int                SEQ_W     = 4,
    parameter int                CTRL_W    = 24,
    parameter int                TX_DEPTH  = 4,
    parameter int                RX_DEPTH  = 4,
    parameter int                STARVE_W  = 6,
    parameter int                STARVE_TH = 8,
    parameter int                PAY_W     = CTRL_W - 1 - 2*ADDR_W - SEQ_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [ADDR_W-1:0] tx_dest,
    input  logic [PAY_W-1:0]  tx_payload,
    output logic [CTRL_W-1:0] port4_ci,
    input  logic              port4_ack,
    input  logic [CTRL_W-1:0] port4_co,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [CTRL_W-1:0] rx_data,
    output logic              starve,
    output logic              rx_overflow
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0]      TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0]      RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_LIM  = STARVE_W'(STARVE_TH);

    // Storage arrays carry no reset: the pointers and counts below are reset,
    // so any stale contents are unreachable after reset.
    logic [CTRL_W-1:0] tx_mem [TX_DEPTH];
    logic [CTRL_W-1:0] rx_mem [RX_DEPTH];

    logic [TX_AW-1:0]    tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [TX_AW:0]      tx_cnt_reg;
    logic [RX_AW-1:0]    rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [RX_AW:0]      rx_cnt_reg;
    logic [SEQ_W-1:0]    seq_reg;
    logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic                starve_reg;
    logic                rx_overflow_reg;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic self_req, eject_valid;
    logic tx_fire, tx_push, loop_push, tx_pop;
    logic rx_pop, ej_push, ej_drop, rx_push;
    logic [CTRL_W-1:0] new_flit, rx_wdata;

    assign tx_empty = (tx_cnt_reg == '0);
    assign tx_full  = (tx_cnt_reg == TX_FULL_CNT);
    assign rx_empty = (rx_cnt_reg == '0);
    assign rx_full  = (rx_cnt_reg == RX_FULL_CNT);

    assign self_req    = (tx_dest == ADDR);
    assign eject_valid = port4_co[CTRL_W-1];

    // A self-addressed request needs the RX write port. Network ejection
    // cannot be stalled, so ejection wins that port, and a loopback is refused
    // whenever RX is full or an ejection arrives in the same cycle.
    assign tx_ready  = !tx_full && !(self_req && (rx_full || eject_valid));
    assign tx_fire   = tx_valid && tx_ready;
    assign tx_push   = tx_fire && !self_req;
    assign loop_push = tx_fire && self_req;
    assign new_flit  = {1'b1, tx_payload, seq_reg, ADDR, tx_dest};

    // An ack while nothing is offered has no effect.
    assign tx_pop = !tx_empty && port4_ack;

    // A same-cycle drain frees a slot for an ejected flit.
    assign rx_pop   = !rx_empty && rx_ready;
    assign ej_push  = eject_valid && (!rx_full || rx_pop);
    assign ej_drop  = eject_valid && rx_full && !rx_pop;
    assign rx_push  = ej_push || loop_push;
    assign rx_wdata = ej_push ? port4_co : new_flit;

    assign port4_ci    = tx_empty ? '0 : tx_mem[tx_rd_ptr_reg];
    assign rx_valid    = !rx_empty;
    assign rx_data     = rx_empty ? '0 : rx_mem[rx_rd_ptr_reg];
    assign starve      = starve_reg;
    assign rx_overflow = rx_overflow_reg;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg] <= new_flit;
        if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_cnt_reg    <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            tx_cnt_reg <= tx_cnt_reg + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr_reg   <= '0;
            rx_rd_ptr_reg   <= '0;
            rx_cnt_reg      <= '0;
            rx_overflow_reg <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            rx_cnt_reg <= rx_cnt_reg + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
            if (ej_drop) rx_overflow_reg <= 1'b1;
        end
    end

    // Every accepted request consumes a sequence number, including loopbacks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       seq_reg <= '0;
        else if (tx_fire) seq_reg <= seq_reg + 1'b1;
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (tx_empty || port4_ack)
            starve_cnt_next = '0;
        else if (starve_cnt_reg != '1)
            starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
            starve_reg     <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            starve_reg     <= (starve_cnt_next >= STARVE_LIM);
        end
    end

endmodule

// File: tb/tb_node_iface.sv
module tb_node_iface;

    localparam int         CTRL_W = 24;
    localparam int         PAY_W  = 11;
    localparam logic [3:0] ADDR   = 4'b0101;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [3:0]        tx_dest = 4'd0;
    logic [PAY_W-1:0]  tx_payload = '0;
    logic [CTRL_W-1:0] port4_ci;
    logic              port4_ack = 1'b0;
    logic [CTRL_W-1:0] port4_co = '0;
    logic              rx_valid;
    logic              rx_ready = 1'b0;
    logic [CTRL_W-1:0] rx_data;
    logic              starve;
    logic              rx_overflow;

    int checks = 0;
    int failures = 0;

    node_iface dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_payload(tx_payload),
        .port4_ci(port4_ci), .port4_ack(port4_ack), .port4_co(port4_co),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .starve(starve), .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (queues) ----------------
    logic [CTRL_W-1:0] m_tx[$];
    logic [CTRL_W-1:0] m_rx[$];
    int                m_seq = 0;
    int                m_stall = 0;
    bit                m_ovf = 1'b0;

    function automatic logic [CTRL_W-1:0] make_flit(logic [3:0] d, logic [PAY_W-1:0] p, int s);
        logic [3:0] s4;
        s4 = 4'(s % 16);
        return {1'b1, p, s4, ADDR, d};
    endfunction

    function automatic bit m_ready();
        bit self_d;
        self_d = (tx_dest == ADDR);
        if (m_tx.size() >= 4) return 1'b0;
        if (self_d && (m_rx.size() >= 4 || port4_co[CTRL_W-1])) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tx.delete();
            m_rx.delete();
            m_seq = 0;
            m_stall = 0;
            m_ovf = 1'b0;
        end else begin
            bit fire;
            fire = tx_valid && m_ready();
            if (m_tx.size() > 0 && !port4_ack) m_stall = (m_stall < 63) ? m_stall + 1 : 63;
            else m_stall = 0;
            if (m_tx.size() > 0 && port4_ack) void'(m_tx.pop_front());
            if (m_rx.size() > 0 && rx_ready) void'(m_rx.pop_front());
            if (port4_co[CTRL_W-1]) begin
                if (m_rx.size() < 4) m_rx.push_back(port4_co);
                else m_ovf = 1'b1;
            end
            if (fire) begin
                if (tx_dest == ADDR) m_rx.push_back(make_flit(tx_dest, tx_payload, m_seq));
                else m_tx.push_back(make_flit(tx_dest, tx_payload, m_seq));
                m_seq = (m_seq + 1) % 16;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("port4_ci", 32'(port4_ci), (m_tx.size() > 0) ? 32'(m_tx[0]) : 32'd0);
        chk("rx_valid", 32'(rx_valid), 32'(m_rx.size() > 0));
        chk("rx_data", 32'(rx_data), (m_rx.size() > 0) ? 32'(m_rx[0]) : 32'd0);
        chk("tx_ready", 32'(tx_ready), 32'(m_ready()));
        chk("starve", 32'(starve), 32'(m_stall >= 8));
        chk("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tx_valid = 1'b0;
        port4_co = '0;
    endtask

    logic [CTRL_W-1:0] ej [5];
    logic [CTRL_W-1:0] net_flit;

    initial begin
        // ---- power-up reset ----
        rst_n = 1'b0; rx_ready = 1'b0; port4_ack = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ci", 32'(port4_ci), 32'd0);
        chk("rst_rxv", 32'(rx_valid), 32'd0);
        chk("rst_txr", 32'(tx_ready), 32'd1);
        $display("txn reset_release done");

        // ---- three requests, ack tied high ----
        port4_ack = 1'b1;
        tx_valid = 1'b1; tx_dest = 4'd3; tx_payload = 11'h123;
        tick(); chk("inj0", 32'(port4_ci), 32'h923053);
        $display("txn inject flit=%h", port4_ci);
        tx_payload = 11'h456;
        tick(); chk("inj1", 32'(port4_ci), 32'hC56153);
        $display("txn inject flit=%h", port4_ci);
        tx_payload = 11'h789;
        tick(); chk("inj2", 32'(port4_ci), 32'hF89253);
        $display("txn inject flit=%h", port4_ci);
        idle();
        tick(); chk("inj_empty", 32'(port4_ci), 32'd0);

        // ---- starvation: one request, ack withheld 10 cycles ----
        port4_ack = 1'b0;
        tx_valid = 1'b1; tx_dest = 4'd3; tx_payload = 11'h7FF;
        tick(); idle();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 7) chk("starve_7", 32'(starve), 32'd0);
            if (i == 8) chk("starve_8", 32'(starve), 32'd1);
            if (i == 10) chk("held_ci", 32'(port4_ci), 32'hFFF353);
        end
        port4_ack = 1'b1;
        tick();
        chk("starve_clr", 32'(starve), 32'd0);
        chk("pop_ci", 32'(port4_ci), 32'd0);
        $display("txn starve sequence done");

        // ---- loopback, then loopback colliding with ejection ----
        port4_ack = 1'b0; rx_ready = 1'b0;
        tx_valid = 1'b1; tx_dest = ADDR; tx_payload = 11'h0AA;
        tick(); idle();
        chk("loop_rxv", 32'(rx_valid), 32'd1);
        chk("loop_data", 32'(rx_data), 32'h8AA455);
        chk("loop_ci", 32'(port4_ci), 32'd0);
        $display("txn loopback flit=%h", rx_data);
        for (int i = 0; i < 2; i++) begin
            port4_co = {1'b1, 23'($urandom)};
            tick();
        end
        net_flit = {1'b1, 23'($urandom)};
        port4_co = net_flit;
        tx_valid = 1'b1; tx_dest = ADDR; tx_payload = 11'h155;
        #1 chk("loop_block", 32'(tx_ready), 32'd0);
        tick();
        port4_co = '0;
        #1 chk("loop_full", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        repeat (3) tick();
        chk("net_kept", 32'(rx_data), 32'(net_flit));
        tick();
        chk("rx_drained", 32'(rx_valid), 32'd0);
        $display("txn loopback collision done");

        // ---- ejection overflow ----
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ej[i] = {1'b1, 23'($urandom)};
            port4_co = ej[i];
            tick();
        end
        port4_co = '0;
        chk("ovf_set", 32'(rx_overflow), 32'd1);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("ovf_order", 32'(rx_data), 32'(ej[i]));
            $display("txn eject drain idx=%0d data=%h", i, rx_data);
            tick();
        end
        chk("ovf_empty", 32'(rx_valid), 32'd0);
        chk("ovf_sticky", 32'(rx_overflow), 32'd1);

        // ---- TX full and sequence wrap ----
        port4_ack = 1'b0;
        tx_valid = 1'b1; tx_dest = 4'd3;
        for (int i = 0; i < 4; i++) begin
            tx_payload = PAY_W'($urandom);
            tick();
        end
        chk("tx_full", 32'(tx_ready), 32'd0);
        port4_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tx_payload = PAY_W'($urandom);
            tick();
        end
        idle();
        repeat (5) tick();
        port4_ack = 1'b0;
        tx_valid = 1'b1; tx_dest = 4'd3; tx_payload = 11'h000;
        tick(); idle();
        chk("seq_wrap", 32'(port4_ci), 32'h800C53);
        $display("txn seq wrap flit=%h", port4_ci);
        port4_ack = 1'b1;
        tick();

        // ---- randomized traffic ----
        for (int i = 0; i < 2000; i++) begin
            tx_valid   = ($urandom_range(0, 1) == 1);
            tx_dest    = ($urandom_range(0, 3) == 0) ? ADDR : 4'($urandom_range(0, 15));
            tx_payload = PAY_W'($urandom);
            port4_ack  = ($urandom_range(0, 2) != 0);
            rx_ready   = ($urandom_range(0, 2) != 0);
            port4_co   = ($urandom_range(0, 2) == 0) ? {1'b1, 23'($urandom)} : {1'b0, 23'($urandom)};
            tick();
        end
        $display("txn random phase done");

        // ---- reset mid-burst: 3 TX queued, 2 RX held ----
        idle(); port4_ack = 1'b1; rx_ready = 1'b1;
        repeat (8) tick();
        port4_ack = 1'b0; rx_ready = 1'b0;
        tx_valid = 1'b1; tx_dest = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tx_payload = PAY_W'($urandom);
            port4_co = (i < 2) ? {1'b1, 23'($urandom)} : '0;
            tick();
        end
        idle();
        chk("burst_rxv", 32'(rx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ci", 32'(port4_ci), 32'd0);
        chk("mid_rst_rxv", 32'(rx_valid), 32'd0);
        chk("mid_rst_txr", 32'(tx_ready), 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ovf", 32'(rx_overflow), 32'd0);
        tx_valid = 1'b1; tx_dest = 4'd3; tx_payload = 11'h001;
        tick(); idle();
        chk("seq_restart", 32'(port4_ci), 32'h801053);
        $display("txn reset mid-burst flit=%h", port4_ci);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
